pckg_block_gen: RTL and testbench
=================================

PCKG_BLOCK_GEN -- requirements
Module: pckg_block_gen

Interface
REQ-001 Parameter NCH, default 3, number of FIFO source channels (1..15).
REQ-002 Parameter DW, default 8, FIFO data width in bits; only bits [7:0] of each word are transmitted.
REQ-003 Parameter PLD_BYTES, default 10, payload bytes per data packet (1..255).
REQ-004 Parameter HDR_TAG, default 4'hF, upper nibble of header byte.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  run enable; level-sensitive.
REQ-008 rdy_cnl  in  4  channel select: 0 = empty packet, k = channel k (1..NCH), >NCH = empty packet.
REQ-009 fifo_dat  in  NCH*DW  concatenated FIFO read data; channel k occupies slice k-1.
REQ-010 fifo_empty  in  NCH  per-channel FIFO empty flag.
REQ-011 rd_en  out  NCH  per-channel FIFO read strobe; read data valid one cycle after strobe.
REQ-012 tx_busy  in  1  LVDS transmitter busy.
REQ-013 data_out  out  8  byte to transmitter.
REQ-014 tx_ena  out  1  single-cycle byte strobe.
REQ-015 next  out  1  single-cycle pulse: packet complete, control block may change rdy_cnl.

Function
REQ-016 Packet format SHALL be: header {HDR_TAG, channel[3:0]}, size byte, payload, checksum byte.
REQ-017 States SHALL be IDLE, HDR, SIZE, RD, CAP, CSUM, NEXT.
REQ-018 IDLE -> HDR when start=1; otherwise remain, all strobes low.
REQ-019 HDR: when tx_busy=0, latch rdy_cnl (mapping >NCH to 0), emit header with channel = latched value, tx_ena=1, clear checksum -> SIZE.
REQ-020 SIZE: when tx_busy=0, emit PLD_BYTES (or 8'h00 for empty), tx_ena=1 -> RD (data) or CSUM (empty).
REQ-021 RD: when tx_busy=0 and fifo_empty of latched channel=0, pulse rd_en of that channel only for one cycle -> CAP; otherwise wait, no strobe.
REQ-022 CAP: drive data_out = fifo word[7:0], tx_ena=1, checksum += byte mod 256, byte counter +1; -> CSUM when counter reaches PLD_BYTES, else RD.
REQ-023 CSUM: when tx_busy=0, emit checksum (8-bit sum of payload bytes mod 256; 8'h00 for empty packet), tx_ena=1 -> NEXT.
REQ-024 NEXT: next=1 for one cycle; -> HDR if start=1, else IDLE.
REQ-025 After any tx_ena cycle the FSM SHALL NOT sample tx_busy in the immediately following cycle (one-cycle guard for transmitter busy latency).
REQ-026 tx_ena, rd_en and next SHALL each be high for exactly one cycle per event; at most one rd_en bit high at any time.
REQ-027 data_out SHALL hold its last value between strobes.
REQ-028 rdy_cnl changes during a packet SHALL be ignored until next HDR.
REQ-029 start deassertion mid-packet SHALL NOT abort; packet completes, then IDLE.
REQ-030 Byte counter width SHALL be 8 bits; no wrap within a packet.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, data_out=8'h00, tx_ena=0, rd_en=0, next=0, checksum=0, counter=0, latched channel=0.
REQ-032 Reset mid-packet SHALL discard the partial packet; no checksum or next emitted.

Structure
REQ-033 State encoding, header tag default and empty-channel code SHALL reside in shared package pckg_gen_pkg.
REQ-034 Checksum accumulator SHALL be sub-module pckg_csum (clear, add-enable, 8-bit byte in, 8-bit sum out).

Verification
REQ-035 NCH=3, PLD_BYTES=4, rdy_cnl=2, FIFO2 holds 01,02,03,04, tx_busy=0 -> bytes F2,04,01,02,03,04,0A; then next pulse.
REQ-036 rdy_cnl=0 -> bytes F0,00,00, next pulse, no rd_en activity.
REQ-037 rdy_cnl=1, fifo_empty[0]=1 for 20 cycles mid-payload -> no rd_en/tx_ena during stall, packet resumes intact.
REQ-038 tx_busy held 1 for 10 cycles after header -> size byte emitted only after tx_busy falls; no duplicate strobes.
REQ-039 payload FF,FF,FF,FF -> checksum FC (mod-256 wrap).
REQ-040 rst asserted during payload byte 2 -> outputs zero same cycle, IDLE; next start produces fresh header.

Source files
------------

// File: rtl/pckg_gen_pkg.sv
// Shared definitions for the packet block generator: FSM states and fixed
// header codes.
package pckg_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SIZE,
    ST_RD,
    ST_CAP,
    ST_CSUM,
    ST_NEXT
  } state_t;

  localparam logic [3:0] HDR_TAG_DEF = 4'hF;
  localparam logic [3:0] EMPTY_CH    = 4'h0;

endpackage

// File: rtl/pckg_block_gen_if.sv
// FIFO-side and transmitter-side signals of the packet block generator.
interface pckg_block_gen_if #(
  parameter int unsigned NCH = 3,
  parameter int unsigned DW  = 8
);
  logic [NCH*DW-1:0] fifo_dat;
  logic [NCH-1:0]    fifo_empty;
  logic [NCH-1:0]    rd_en;
  logic              tx_busy;
  logic [7:0]        data_out;
  logic              tx_ena;

  modport master (
    input  fifo_dat, fifo_empty, tx_busy,
    output rd_en, data_out, tx_ena
  );

  modport slave (
    output fifo_dat, fifo_empty, tx_busy,
    input  rd_en, data_out, tx_ena
  );
endinterface

// File: rtl/pckg_csum.sv
// 8-bit modulo-256 checksum accumulator with synchronous clear.
module pckg_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sum <= '0;
    else if (clr)    sum <= '0;
    else if (add_en) sum <= sum + byte_in;
  end

endmodule

// File: rtl/pckg_block_gen.sv
// Packet generator: header, size, payload read from one FIFO channel, checksum,
// emitted byte by byte to an LVDS transmitter.
module pckg_block_gen
  import pckg_gen_pkg::*;
#(
  parameter int unsigned NCH       = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned PLD_BYTES = 10,
  parameter logic [3:0]  HDR_TAG   = HDR_TAG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         rdy_cnl,
  output logic               next,
  pckg_block_gen_if.master   bus
);

  state_t         state, state_d;
  logic [3:0]     ch_q, ch_d, rdy_map;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     dout_q, dout_d;
  logic           tx_ena_q, tx_ena_d;
  logic           tx_guard;
  logic           go;
  logic           ch_empty;
  logic [7:0]     ch_byte;
  logic [NCH-1:0] rd_en_c;
  logic           csum_clr, csum_add;
  logic [7:0]     csum;

  assign bus.rd_en    = rd_en_c;
  assign bus.data_out = dout_q;
  assign bus.tx_ena   = tx_ena_q;

  assign rdy_map = (rdy_cnl == EMPTY_CH || 32'(rdy_cnl) > NCH) ? EMPTY_CH : rdy_cnl;

  // tx_ena is registered, so busy is ignored both in the strobe cycle and the one after
  assign go = !bus.tx_busy && !tx_ena_q && !tx_guard;

  always_comb begin
    ch_empty = 1'b1;
    ch_byte  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_q == 4'(i + 1)) begin
        ch_empty = bus.fifo_empty[i];
        ch_byte  = bus.fifo_dat[i*DW +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ch_q     <= EMPTY_CH;
      cnt_q    <= '0;
      dout_q   <= '0;
      tx_ena_q <= 1'b0;
      tx_guard <= 1'b0;
    end else begin
      state    <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      tx_ena_q <= tx_ena_d;
      tx_guard <= tx_ena_q;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start) state_d = ST_HDR;
      ST_HDR:  if (go) state_d = ST_SIZE;
      ST_SIZE: if (go) state_d = (ch_q == EMPTY_CH) ? ST_CSUM : ST_RD;
      ST_RD:   if (go && !ch_empty) state_d = ST_CAP;
      ST_CAP:  state_d = (8'(cnt_q + 8'd1) == 8'(PLD_BYTES)) ? ST_CSUM : ST_RD;
      ST_CSUM: if (go) state_d = ST_NEXT;
      ST_NEXT: state_d = start ? ST_HDR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    tx_ena_d = 1'b0;
    csum_clr = 1'b0;
    csum_add = 1'b0;
    rd_en_c  = '0;
    next     = 1'b0;
    case (state)
      ST_HDR: if (go) begin
        ch_d     = rdy_map;
        cnt_d    = '0;
        dout_d   = {HDR_TAG, rdy_map};
        tx_ena_d = 1'b1;
        csum_clr = 1'b1;
      end
      ST_SIZE: if (go) begin
        dout_d   = (ch_q == EMPTY_CH) ? 8'h00 : 8'(PLD_BYTES);
        tx_ena_d = 1'b1;
      end
      ST_RD: if (go && !ch_empty) begin
        for (int unsigned i = 0; i < NCH; i++) rd_en_c[i] = (ch_q == 4'(i + 1));
      end
      ST_CAP: begin
        dout_d   = ch_byte;
        tx_ena_d = 1'b1;
        csum_add = 1'b1;
        cnt_d    = cnt_q + 8'd1;
      end
      ST_CSUM: if (go) begin
        dout_d   = csum;
        tx_ena_d = 1'b1;
      end
      ST_NEXT: next = 1'b1;
      default: ;
    endcase
  end

  pckg_csum u_csum (
    .clk     (clk),
    .rst     (rst),
    .clr     (csum_clr),
    .add_en  (csum_add),
    .byte_in (ch_byte),
    .sum     (csum)
  );

endmodule

// File: tb/tb_pckg_block_gen.sv
// Self-checking bench for pckg_block_gen: FIFO/transmitter models, expected
// packets built from the packet format rules.
module tb_pckg_block_gen;

  localparam int NCH = 3;
  localparam int PLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] rdy_cnl;
  logic       next_o;

  logic [7:0]     fq [NCH][$];
  logic [7:0]     dat_r [NCH];
  logic [NCH-1:0] emp_q = '1;
  logic [NCH-1:0] stall_v;

  logic [7:0] cap [$];
  int rd_tot = 0, next_tot = 0, dbl = 0, multi = 0;
  logic tx_prev = 1'b0, nx_prev = 1'b0, rd_prev = 1'b0;

  int checks = 0;
  int errors = 0;

  pckg_block_gen_if #(.NCH(NCH), .DW(8)) bus ();

  pckg_block_gen #(.NCH(NCH), .DW(8), .PLD_BYTES(PLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rdy_cnl (rdy_cnl),
    .next    (next_o),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.fifo_dat   = {dat_r[2], dat_r[1], dat_r[0]};
  assign bus.fifo_empty = emp_q | stall_v;

  // FIFO model: data appears the cycle after the read strobe
  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (bus.rd_en[k] && fq[k].size() > 0) begin
        dat_r[k] <= fq[k][0];
        void'(fq[k].pop_front());
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) emp_q[k] <= (fq[k].size() == 0);
  end

  always @(negedge clk) begin
    if (bus.tx_ena) cap.push_back(bus.data_out);
    if (bus.rd_en != '0) rd_tot <= rd_tot + 1;
    if (next_o) next_tot <= next_tot + 1;
    if ($countones(bus.rd_en) > 1) multi <= multi + 1;
    dbl <= dbl + int'(bus.tx_ena && tx_prev) + int'(next_o && nx_prev)
               + int'((bus.rd_en != '0) && rd_prev);
    tx_prev <= bus.tx_ena;
    nx_prev <= next_o;
    rd_prev <= (bus.rd_en != '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int n, input string tag);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_ena) seen++;
    end
    check({"tx_wait ", tag}, seen, n);
  endtask

  task automatic wait_next(input string tag);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (next_o) seen = 1;
    end
    check({"next_wait ", tag}, 32'(seen), 32'd1);
  endtask

  task automatic quiet(input int n, input string tag);
    int act = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.tx_ena || bus.rd_en != '0 || next_o) act++;
    end
    check(tag, act, 0);
  endtask

  // mode: 0 random payload, 1 = 01..04, 2 = all FF
  task automatic run_pkt(input logic [3:0] ch, input int mode, input bit busy_hdr,
                         input bit stall_mid, input string tag);
    logic [3:0] ce;
    logic [7:0] b;
    logic [7:0] ex [$];
    int sum = 0;
    int rd0, nx0;
    ce = (ch == 4'd0 || ch > 4'(NCH)) ? 4'd0 : ch;
    ex.push_back({4'hF, ce});
    ex.push_back(ce == 0 ? 8'h00 : 8'(PLD));
    if (ce != 0) begin
      for (int i = 0; i < PLD; i++) begin
        b = (mode == 1) ? 8'(i + 1) : (mode == 2) ? 8'hFF : 8'($urandom);
        fq[ce-1].push_back(b);
        ex.push_back(b);
        sum += b;
      end
    end
    ex.push_back(8'(sum % 256));
    @(posedge clk); #1;
    cap.delete();
    rd0 = rd_tot;
    nx0 = next_tot;
    rdy_cnl = ch;
    start = 1'b1;
    wait_tx(1, tag);
    rdy_cnl = 4'($urandom);
    start = 1'b0;
    if (busy_hdr) begin
      bus.tx_busy = 1'b1;
      quiet(10, {"busy_quiet ", tag});
      bus.tx_busy = 1'b0;
    end
    if (stall_mid && ce != 0) begin
      wait_tx(3, tag);
      stall_v[ce-1] = 1'b1;
      quiet(20, {"stall_quiet ", tag});
      stall_v[ce-1] = 1'b0;
    end
    wait_next(tag);
    quiet(6, {"idle_after ", tag});
    @(posedge clk); #1;
    check({"nbytes ", tag}, cap.size(), ex.size());
    for (int i = 0; i < ex.size() && i < cap.size(); i++)
      check($sformatf("byte%0d %s", i, tag), cap[i], ex[i]);
    check({"rd_cnt ", tag}, rd_tot - rd0, (ce == 0) ? 0 : PLD);
    check({"next_cnt ", tag}, next_tot - nx0, 1);
  endtask

  initial begin
    int nx0;
    rst = 1'b1;
    start = 1'b0;
    rdy_cnl = '0;
    bus.tx_busy = 1'b0;
    stall_v = '0;
    for (int k = 0; k < NCH; k++) dat_r[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst data_out", bus.data_out, 8'h00);
    check("rst tx_ena", bus.tx_ena, 1'b0);
    check("rst rd_en", bus.rd_en, '0);
    check("rst next", next_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_pkt(4'd2, 1, 1'b0, 1'b0, "ch2_fixed");
    run_pkt(4'd0, 0, 1'b0, 1'b0, "empty0");
    run_pkt(4'd1, 0, 1'b0, 1'b1, "ch1_stall");
    run_pkt(4'd3, 0, 1'b1, 1'b0, "ch3_busy");
    run_pkt(4'd2, 2, 1'b0, 1'b0, "ch2_ff");
    run_pkt(4'd9, 0, 1'b0, 1'b0, "ch9_empty");

    // reset in the middle of the payload
    for (int i = 0; i < PLD; i++) fq[0].push_back(8'($urandom));
    @(posedge clk); #1;
    nx0 = next_tot;
    rdy_cnl = 4'd1;
    start = 1'b1;
    wait_tx(3, "midrst");
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst data_out", bus.data_out, 8'h00);
    check("midrst tx_ena", bus.tx_ena, 1'b0);
    check("midrst rd_en", bus.rd_en, '0);
    check("midrst next", next_o, 1'b0);
    repeat (3) @(posedge clk);
    fq[0].delete();
    @(negedge clk);
    rst = 1'b0;
    quiet(5, "midrst_quiet");
    check("midrst no_next", next_tot - nx0, 0);
    run_pkt(4'd1, 0, 1'b0, 1'b0, "after_rst");

    for (int n = 0; n < 5; n++)
      run_pkt(4'($urandom_range(0, 6)), 0, 1'($urandom_range(0, 1)), 1'b0,
              $sformatf("rand%0d", n));

    @(posedge clk); #1;
    check("double_strobe", dbl, 0);
    check("multi_rd_en", multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
